// File: rtl/ahb_slave_if_if.sv
// AHB slave-side bus bundle for ahb_slave_if: AHB address/data phase, APB read data
// return, pipeline stage outputs and response signals.
interface ahb_slave_if_if;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        Valid;
  logic [31:0] Haddr1;
  logic [31:0] Haddr2;
  logic [31:0] Hdata1;
  logic [31:0] Hdata2;
  logic        Hwrite_reg;
  logic        Hwrite_reg1;
  logic [2:0]  Tempselx;
  logic [31:0] Hrdata;
  logic [1:0]  Hresp;
  logic        Err_stall;

  modport slave (
    input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
    output Valid, Haddr1, Haddr2, Hdata1, Hdata2, Hwrite_reg, Hwrite_reg1,
           Tempselx, Hrdata, Hresp, Err_stall
  );

  modport master (
    output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata,
    input  Valid, Haddr1, Haddr2, Hdata1, Hdata2, Hwrite_reg, Hwrite_reg1,
           Tempselx, Hrdata, Hresp, Err_stall
  );
endinterface

// File: rtl/ahb_slave_if.sv
// AHB slave front end of an AHB-to-APB bridge: address decode, two-stage pipeline, read return.
// Define AHB_ERR_RESP_EN to get the two-cycle ERROR response for unmapped transfers.
module ahb_slave_if (
  input logic             Hclk,
  input logic             Hreset,
  ahb_slave_if_if.slave   bus
);

  logic mapped;

  always_comb begin
    bus.Tempselx = 3'b000;
    if (bus.Haddr >= 32'h8000_0000 && bus.Haddr < 32'h8400_0000) begin
      bus.Tempselx = 3'b001;
    end else if (bus.Haddr >= 32'h8400_0000 && bus.Haddr < 32'h8800_0000) begin
      bus.Tempselx = 3'b010;
    end else if (bus.Haddr >= 32'h8800_0000 && bus.Haddr < 32'h8C00_0000) begin
      bus.Tempselx = 3'b100;
    end
  end

  assign mapped    = (bus.Tempselx != 3'b000);
  assign bus.Valid = bus.Hreadyin & bus.Htrans[1] & mapped;
  assign bus.Hrdata = bus.Prdata;

  // Pipeline loads on every ready edge regardless of Htrans; Valid qualifies use downstream.
  always_ff @(posedge Hclk) begin
    if (!Hreset) begin
      bus.Haddr1      <= 32'h0;
      bus.Haddr2      <= 32'h0;
      bus.Hdata1      <= 32'h0;
      bus.Hdata2      <= 32'h0;
      bus.Hwrite_reg  <= 1'b0;
      bus.Hwrite_reg1 <= 1'b0;
    end else if (bus.Hreadyin) begin
      bus.Haddr1      <= bus.Haddr;
      bus.Haddr2      <= bus.Haddr1;
      bus.Hdata1      <= bus.Hwdata;
      bus.Hdata2      <= bus.Hdata1;
      bus.Hwrite_reg  <= bus.Hwrite;
      bus.Hwrite_reg1 <= bus.Hwrite_reg;
    end
  end

`ifdef AHB_ERR_RESP_EN
  typedef enum logic [1:0] {StOkay, StErr1, StErr2} err_state_e;

  err_state_e err_state_q, err_state_d;
  logic       err_hit;

  assign err_hit = bus.Hreadyin & bus.Htrans[1] & ~mapped;

  always_ff @(posedge Hclk) begin
    if (!Hreset) begin
      err_state_q <= StOkay;
    end else begin
      err_state_q <= err_state_d;
    end
  end

  // Any new unmapped transfer restarts the sequence at its first cycle.
  always_comb begin
    err_state_d   = StOkay;
    bus.Hresp     = 2'b00;
    bus.Err_stall = 1'b0;
    if (err_hit) begin
      err_state_d = StErr1;
    end else if (err_state_q == StErr1) begin
      err_state_d = StErr2;
    end
    unique case (err_state_q)
      StErr1: begin
        bus.Hresp     = 2'b01;
        bus.Err_stall = 1'b1;
      end
      StErr2: bus.Hresp = 2'b01;
      default: ;
    endcase
  end
`else
  assign bus.Hresp     = 2'b00;
  assign bus.Err_stall = 1'b0;
`endif

endmodule
